fpu_mul_sched: RTL

- Round-robin scheduler sharing one FP32 multiplier core (combinational sign/exponent/mantissa datapath, rounding, five exception flags) between two requesters (0, 1).
- Registers the winning operands, waits a fixed settle latency, captures the result and flags, and returns them on a tagged response handshake.
- Keeps a sticky per-requester exception register, clearable per requester.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/fpu_mul_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier scheduler: field widths, rounding modes,
// exception flag positions and scheduler FSM encoding.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RZ  = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  localparam int unsigned FLG_W   = 5;
  localparam int unsigned FLG_INV = 4;
  localparam int unsigned FLG_OVF = 3;
  localparam int unsigned FLG_UNF = 2;
  localparam int unsigned FLG_INX = 1;
  localparam int unsigned FLG_ZER = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the favoured requester on a tie
// and moves to the other index whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After any grant the pointer favours the requester that did not win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (en && (req != 2'b00)) begin
      ptr_q <= ~gnt[1];
    end
  end

endmodule

// File: rtl/fpu_mul_sched.sv
// Shares one external FP32 multiplier core between two requesters: registers the winning
// operands, waits MUL_LAT cycles, captures the result and returns it on a tagged response.
module fpu_mul_sched
  import fpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     opx_0,
  input  logic [W-1:0]     opy_0,
  input  logic [W-1:0]     opx_1,
  input  logic [W-1:0]     opy_1,
  input  logic [1:0]       rmode_0,
  input  logic [1:0]       rmode_1,
  output logic [W-1:0]     mul_x,
  output logic [W-1:0]     mul_y,
  output logic [1:0]       mul_rmode,
  input  logic [W-1:0]     mul_z,
  input  logic [FLG_W-1:0] mul_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_z,
  output logic [FLG_W-1:0] rsp_flags,
  output logic [FLG_W-1:0] sticky_0,
  output logic [FLG_W-1:0] sticky_1,
  input  logic [1:0]       sticky_clr,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             tag;
  logic [1:0]       gnt;
  logic             accept;
  logic             win;

  assign accept    = (state == StIdle) && (req_valid != 2'b00);
  assign req_ready = (state == StIdle) ? gnt : 2'b00;
  assign win       = gnt[1];
  assign busy      = (state != StIdle);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (accept),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      tag       <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_rmode <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      sticky_0  <= '0;
      sticky_1  <= '0;
    end else begin
      if (sticky_clr[0]) sticky_0 <= '0;
      if (sticky_clr[1]) sticky_1 <= '0;

      unique case (state)
        StIdle: begin
          if (accept) begin
            mul_x     <= win ? opx_1 : opx_0;
            mul_y     <= win ? opy_1 : opy_0;
            mul_rmode <= win ? rmode_1 : rmode_0;
            tag       <= win;
            cnt       <= CNT_W'(MUL_LAT - 1);
            state     <= StWait;
          end
        end
        StWait: begin
          if (cnt == '0) begin
            rsp_z     <= mul_z;
            rsp_flags <= mul_flags;
            rsp_valid <= 1'b1;
            rsp_id    <= tag;
            state     <= StResp;
            // A same-cycle clear drops old bits but keeps the flags being captured.
            if (tag) begin
              sticky_1 <= (sticky_clr[1] ? '0 : sticky_1) | mul_flags;
            end else begin
              sticky_0 <= (sticky_clr[0] ? '0 : sticky_0) | mul_flags;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
